rr_arb_enc_16_4: RTL and testbench

RR_ARB_ENC_16_4 -- requirements
Module: rr_arb_enc_16_4

---
 rtl/decoder_4_16.sv | 12 +
 rtl/rr_arb_enc_16_4.sv | 59 +++++
 tb/tb_rr_arb_enc_16_4.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/decoder_4_16.sv
// 4-to-16 binary-to-one-hot decoder shared across the lab codebase.
module decoder_4_16 (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_enc_16_4.sv
// 16-requester round-robin arbiter with a registered, binary-encoded grant
// and a valid/ready output handshake; the winner becomes lowest priority.
module rr_arb_enc_16_4 (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic [15:0] out_onehot
);

  localparam int NumReq = 16;
  localparam int IdxW   = 4;

  logic [IdxW-1:0]   ptr;
  logic [IdxW:0]     pick;
  logic              slot_free;
  logic [NumReq-1:0] dec_onehot;

  // Double-width scan: bits below ptr are masked in the low copy, so the
  // lowest surviving set bit is the first requester at or after ptr.
  function automatic logic [IdxW:0] rr_pick(input logic [NumReq-1:0] r,
                                            input logic [IdxW-1:0]   p);
    logic [2*NumReq-1:0] dbl;
    logic [IdxW:0]       res;
    res = '0;
    dbl = {r, r} & ({(2*NumReq){1'b1}} << p);
    for (int i = 2*NumReq-1; i >= 0; i--) begin
      if (dbl[i]) res = {1'b1, i[IdxW-1:0]};
    end
    return res;
  endfunction

  assign pick      = rr_pick(req, ptr);
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= '0;
    end else if (slot_free) begin
      out_valid <= pick[IdxW];
      if (pick[IdxW]) begin
        out_idx <= pick[IdxW-1:0];
        ptr     <= pick[IdxW-1:0] + 1'b1;
      end
    end
  end

  decoder_4_16 u_dec (
    .idx    (out_idx),
    .onehot (dec_onehot)
  );

  assign out_onehot = dec_onehot & {NumReq{out_valid}};

endmodule

// File: tb/tb_rr_arb_enc_16_4.sv
// Directed bench for rr_arb_enc_16_4: stimulus pushes expected grants into a
// queue, a negedge monitor compares every presented grant against the head.
module tb_rr_arb_enc_16_4;

  typedef struct {
    logic [3:0] idx;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [15:0] out_onehot;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic lastValid = 1'b0;
  logic lastReady = 1'b0;

  rr_arb_enc_16_4 dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic rdy);
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
  endtask

  task automatic expectGrant(input logic [3:0] idx);
    exp_t e;
    e.idx = idx;
    e.due = cyc + 1;
    expQ.push_back(e);
  endtask

  // Monitor: a grant is "fresh" on its first visible cycle, where its timing is checked.
  always @(negedge clk) begin
    logic fresh;
    fresh = !lastValid || lastReady;
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (fresh) checkOutput("grant_cycle", cyc, expQ[0].due);
        checkOutput("out_idx", {28'b0, out_idx}, {28'b0, expQ[0].idx});
        checkOutput("out_onehot", {16'b0, out_onehot}, 32'd1 << expQ[0].idx);
        if (out_ready) void'(expQ.pop_front());
      end
    end else begin
      checkOutput("onehot_idle", {16'b0, out_onehot}, 32'd0);
    end
    lastValid = out_valid;
    lastReady = out_ready;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn    = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #2;
    checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_onehot", {16'b0, out_onehot}, 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    out_ready = 1'b1;

    // Idle with ready high: nothing may be granted.
    repeat (5) applyStimulus(16'h0000, 1'b1);
    checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);

    // Single request, then a back-to-back grant that proves ptr advanced to 6.
    applyStimulus(16'h0020, 1'b1); expectGrant(4'd5);
    applyStimulus(16'h0070, 1'b1); expectGrant(4'd6);
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b0);

    // Mid-cycle reset pulse to return ptr to 0.
    @(posedge clk);
    #1 resetn = 1'b0;
    #1 checkOutput("reset_async_valid", {31'b0, out_valid}, 32'd0);
    #1 resetn = 1'b1;

    // Round-robin order with everything ready.
    applyStimulus(16'h8421, 1'b1); expectGrant(4'd0);
    applyStimulus(16'h8421, 1'b1); expectGrant(4'd5);
    applyStimulus(16'h8421, 1'b1); expectGrant(4'd10);
    applyStimulus(16'h8421, 1'b1); expectGrant(4'd15);
    applyStimulus(16'h8421, 1'b1); expectGrant(4'd0);
    applyStimulus(16'h0000, 1'b1);

    // Backpressure: idx 3 held through a req change, then idx 8 follows.
    applyStimulus(16'h0008, 1'b0); expectGrant(4'd3);
    repeat (4) applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'h0100, 1'b1); expectGrant(4'd8);
    applyStimulus(16'h0000, 1'b1);

    // Wrap-around: grant 13 leaves ptr at 14, then req bit 0 wins.
    applyStimulus(16'h2000, 1'b1); expectGrant(4'd13);
    applyStimulus(16'h0001, 1'b1); expectGrant(4'd0);
    applyStimulus(16'h8000, 1'b1); expectGrant(4'd15);
    applyStimulus(16'h8001, 1'b1); expectGrant(4'd0);
    applyStimulus(16'h0000, 1'b1);

    // Reset while idx 7 is held; the pending grant must not reappear.
    applyStimulus(16'h0080, 1'b0); expectGrant(4'd7);
    applyStimulus(16'h0080, 1'b0);
    #1 resetn = 1'b0;
    #1;
    checkOutput("midhold_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midhold_idx", {28'b0, out_idx}, 32'd0);
    checkOutput("midhold_onehot", {16'b0, out_onehot}, 32'd0);
    expQ.delete();
    req       = 16'h0081;
    out_ready = 1'b1;
    expectGrant(4'd0);
    #1 resetn = 1'b1;
    applyStimulus(16'h0000, 1'b1);
    repeat (4) applyStimulus(16'h0000, 1'b1);

    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
